// File: rtl/cnt_en_clr_ovf.sv
// Binary up-counter with synchronous enable/clear and a one-cycle wrap flag.
// Latency: one cycle from sampled inputs to registered outputs; no backpressure, accepts every edge.
module cnt_en_clr_ovf #(
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 arstn_i,
   input  logic                 cnt_en_i,
   input  logic                 cnt_clr_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 ovf_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Clear outranks enable so a clear at max never reports a wrap.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
      end else if (cnt_clr_i) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
      end else if (cnt_en_i) begin
         if (cnt_o == CNT_MAX) begin
            cnt_o <= '0;
            ovf_o <= 1'b1;
         end else begin
            cnt_o <= cnt_o + CNT_ONE;
            ovf_o <= 1'b0;
         end
      end else begin
         ovf_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cnt_en_clr_ovf.sv
// Directed bench for cnt_en_clr_ovf with a scoreboard of expected outputs per edge.
module tb_cnt_en_clr_ovf;

   localparam int W   = 4;
   localparam int MAX = (1 << W) - 1;

   typedef struct {
      logic [W-1:0] cnt;
      logic         ovf;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         arstn_i;
   logic         cnt_en_i;
   logic         cnt_clr_i;
   logic [W-1:0] cnt_o;
   logic         ovf_o;

   int   n_vec = 0;
   int   n_err = 0;
   int   m_cnt = 0;
   logic m_ovf = 1'b0;
   exp_t sb[$];

   cnt_en_clr_ovf #(.CNT_WIDTH(W)) dut (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .cnt_en_i  (cnt_en_i),
      .cnt_clr_i (cnt_clr_i),
      .cnt_o     (cnt_o),
      .ovf_o     (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one edge's inputs, push the spec-derived result, then compare after the edge.
   task automatic step(input string tag, input logic en, input logic clr);
      exp_t e;
      exp_t got;
      @(negedge clk_i);
      cnt_en_i  = en;
      cnt_clr_i = clr;
      if (clr) begin
         m_cnt = 0;
         m_ovf = 1'b0;
      end else if (en) begin
         m_ovf = (m_cnt == MAX);
         m_cnt = (m_cnt + 1) % (MAX + 1);
      end else begin
         m_ovf = 1'b0;
      end
      e.cnt = m_cnt[W-1:0];
      e.ovf = m_ovf;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      got = sb.pop_front();
      check({tag, ".cnt"}, 32'(cnt_o), 32'(got.cnt));
      check({tag, ".ovf"}, 32'(ovf_o), 32'(got.ovf));
   endtask

   initial begin
      arstn_i   = 1'b0;
      cnt_en_i  = 1'b0;
      cnt_clr_i = 1'b0;
      #2;
      check("rst_cnt", 32'(cnt_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      #8;
      arstn_i = 1'b1;

      for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0);

      // 16 enabled edges: 1..15 then wrap to 0 with ovf, then back to 1 with ovf low.
      for (int i = 0; i < 16; i++) step("wrap", 1'b1, 1'b0);
      check("wrap_at0_cnt", 32'(cnt_o), 32'd0);
      check("wrap_at0_ovf", 32'(ovf_o), 32'd1);
      step("post_wrap", 1'b1, 1'b0);
      check("post_wrap_ovf_low", 32'(ovf_o), 32'd0);

      for (int i = 0; i < 4; i++) step("to5", 1'b1, 1'b0);
      check("at5", 32'(cnt_o), 32'd5);
      for (int i = 0; i < 2; i++) step("hold", 1'b0, 1'b0);
      check("hold5", 32'(cnt_o), 32'd5);
      step("resume", 1'b1, 1'b0);
      step("resume", 1'b1, 1'b0);
      check("at7", 32'(cnt_o), 32'd7);

      step("to9", 1'b1, 1'b0);
      step("to9", 1'b1, 1'b0);
      check("at9", 32'(cnt_o), 32'd9);
      step("clr9", 1'b1, 1'b1);
      check("clr9_cnt", 32'(cnt_o), 32'd0);
      step("after_clr", 1'b1, 1'b0);
      check("after_clr_cnt", 32'(cnt_o), 32'd1);

      for (int i = 0; i < 14; i++) step("to15", 1'b1, 1'b0);
      check("at15", 32'(cnt_o), 32'd15);
      step("clr_at_max", 1'b1, 1'b1);
      check("clr_max_cnt", 32'(cnt_o), 32'd0);
      check("clr_max_ovf", 32'(ovf_o), 32'd0);
      step("after_clr_max", 1'b1, 1'b0);

      step("to3", 1'b1, 1'b0);
      step("to3", 1'b1, 1'b0);
      check("at3", 32'(cnt_o), 32'd3);

      // Asynchronous reset between edges: outputs clear without a clock edge.
      #2;
      cnt_en_i = 1'b0;
      arstn_i  = 1'b0;
      #1;
      check("async_cnt", 32'(cnt_o), 32'd0);
      check("async_ovf", 32'(ovf_o), 32'd0);
      m_cnt = 0;
      m_ovf = 1'b0;
      #20;
      check("rst_hold_cnt", 32'(cnt_o), 32'd0);
      @(negedge clk_i);
      cnt_en_i = 1'b1;
      arstn_i  = 1'b1;
      @(posedge clk_i);
      #1;
      check("rel1_cnt", 32'(cnt_o), 32'd1);
      m_cnt = 1;
      step("rel2", 1'b1, 1'b0);
      check("rel2_cnt", 32'(cnt_o), 32'd2);

      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cnt_en_clr_ovf.md
Name: cnt_en_clr_ovf

Overview:
- Parameterised binary up-counter with synchronous enable, synchronous clear and a one-cycle overflow (wrap) flag.
- General-purpose timing/event-count primitive for use inside larger control blocks.
- Single clock domain; asynchronous active-low reset.

Parameters:
- CNT_WIDTH, 4, counter width in bits; legal range 1..32; maximum count is 2^CNT_WIDTH-1.

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- arstn_i  input  1  asynchronous reset, active-low; assertion immediately clears state, release is synchronised externally
- cnt_en_i  input  1  count enable; counter increments on each rising edge while high
- cnt_clr_i  input  1  synchronous clear; counter returns to 0 on next rising edge
- cnt_o  output  CNT_WIDTH  current count value, registered
- ovf_o  output  1  overflow flag, registered, high for exactly one cycle after a wrap from max to 0

Behaviour:
- Reset:
  - arstn_i low forces cnt_o=0 and ovf_o=0 immediately, independent of clk_i.
  - Both outputs are held while arstn_i stays low.
  - Reset asserted mid-count discards the count; counting resumes from 0 on the first enabled edge after release.
- Per rising edge of clk_i, with arstn_i high, priority order:
  - cnt_clr_i=1: cnt_o<=0, ovf_o<=0, regardless of cnt_en_i.
  - cnt_en_i=1 and cnt_o==max: cnt_o<=0, ovf_o<=1.
  - cnt_en_i=1 and cnt_o<max: cnt_o<=cnt_o+1, ovf_o<=0.
  - cnt_en_i=0: cnt_o holds, ovf_o<=0.
- Latency: one cycle from an input sampled on an edge to the visible output change.
- Arithmetic: unsigned, modulo 2^CNT_WIDTH, no saturation.
- ovf_o:
  - High only in the cycle where cnt_o has just become 0 by wrapping.
  - A clear never raises ovf_o.
  - Clear and enable both high at max: clear wins, no overflow.
- Enable deasserted: the count freezes indefinitely with no drift.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- No shared package needed; CNT_WIDTH is a local parameter of the block.
- The max-value constant is derived internally as all-ones of CNT_WIDTH.
- No sub-module; single flat module with one counter register and one flag register.

Test Plan:
- Clock period is 10 ns in all scenarios.
- Reset: arstn_i low 10 ns, then high, en=0, clr=0 -> cnt_o=0, ovf_o=0 and held for several edges.
- Count and wrap (CNT_WIDTH=4): en=1 from 0 for 16 edges -> cnt_o steps 1..15, then 0 with ovf_o=1 for exactly one cycle; next edge gives cnt_o=1, ovf_o=0.
- Hold: en=1 until cnt_o=5, then en=0 for 2 edges -> cnt_o stays 5, ovf_o=0; en=1 again -> 6, 7, ...
- Clear: while counting at cnt_o=9, clr=1 for one edge -> cnt_o=0, ovf_o=0; with en still 1 the next edge gives 1. Clear at cnt_o=15 with en=1 -> 0, ovf_o stays 0.
- Async reset mid-count: at cnt_o=3, drop arstn_i between edges -> cnt_o=0 before the next edge; hold low 20 ns; release with en=1 -> 1, 2, ... from the first edge after release.
